// File: rtl/pps_pkg.sv
// Shared definitions for the pps_multi_blink LED blinker: counter width and the
// duty-to-threshold conversion used by every channel.
package pps_pkg;

  localparam int CW = 32;

  typedef logic [CW-1:0] cnt_t;

  // Threshold in clock cycles for a duty value: (duty * rate) >> bits.
  // The product is formed at 64 bits, so any duty up to 32 bits times a
  // 32-bit rate fits before the shift and the final truncation.
  function automatic cnt_t duty_to_thr(input logic [31:0] duty,
                                       input logic [31:0] rate,
                                       input int unsigned bits);
    logic [63:0] prod;
    prod = 64'(duty) * 64'(rate);
    return cnt_t'(prod >> bits);
  endfunction

endpackage

// File: rtl/pps_multi_blink_if.sv
// Duty write port of pps_multi_blink: a single strobe, channel index and duty value,
// always accepted with no backpressure.
interface pps_multi_blink_if #(
    parameter int NCHAN     = 4,
    parameter int DUTY_BITS = 8
);
    localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic                 wr_stb;
    logic [CHW-1:0]       wr_chan;
    logic [DUTY_BITS-1:0] wr_duty;

    modport master (output wr_stb, wr_chan, wr_duty);
    modport slave  (input  wr_stb, wr_chan, wr_duty);
endinterface

// File: rtl/pps_chan.sv
// One LED channel: double-buffered duty (pending -> active at the frame wrap),
// threshold compare against the shared counter, and the registered LED output.
module pps_chan
    import pps_pkg::*;
#(
    parameter int unsigned CLOCK_RATE_HZ = 50_000_000,
    parameter int unsigned DUTY_BITS     = 8,
    parameter int unsigned DEFAULT_DUTY  = 128
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  cnt_t                 counter_next,
    input  logic                 wrap,
    input  logic                 wr_en,
    input  logic [DUTY_BITS-1:0] wr_duty,
    output logic                 o_led
);

    localparam logic [DUTY_BITS-1:0] DUTY_MAX = '1;
    localparam logic [DUTY_BITS-1:0] DUTY_RST = DUTY_BITS'(DEFAULT_DUTY);

    logic [DUTY_BITS-1:0] pending, pending_next;
    logic [DUTY_BITS-1:0] active_duty, active_duty_next;
    cnt_t                 active_thr, active_thr_next;
    logic                 led_next;

    // A write on the wrap cycle reaches the commit through pending_next, so it
    // lands in the frame that is just starting rather than one frame later.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        pending_next     = wr_en ? wr_duty : pending;
        active_duty_next = active_duty;
        active_thr_next  = active_thr;
        if (wrap) begin
            active_duty_next = pending_next;
            active_thr_next  = duty_to_thr(32'(pending_next), 32'(CLOCK_RATE_HZ), DUTY_BITS);
        end
        // Full-scale duty is forced on; its threshold is a few cycles short of a frame.
        led_next = (active_duty_next == DUTY_MAX) || (counter_next < active_thr_next);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) begin
            pending     <= DUTY_RST;
            active_duty <= '0;
            active_thr  <= '0;
            o_led       <= 1'b0;
        end else begin
            pending     <= pending_next;
            active_duty <= active_duty_next;
            active_thr  <= active_thr_next;
            o_led       <= led_next;
        end
    end

`ifdef FORMAL
    a_thr_on_wrap: assert property (@(posedge i_clk)
        (!$past(wrap) && !$past(i_reset)) |-> $stable(active_thr));
`endif

endmodule

// File: rtl/pps_multi_blink.sv
// Multi-channel 1 Hz LED blinker: shared frame prescaler, 1 Hz strobe and per-channel
// duty outputs. Define PPS_SYNC_EN to add the i_pps_sync external frame-alignment input.
module pps_multi_blink
    import pps_pkg::*;
#(
    parameter int unsigned CLOCK_RATE_HZ = 50_000_000,
    parameter int unsigned NCHAN         = 4,
    parameter int unsigned DUTY_BITS     = 8,
    parameter int unsigned DEFAULT_DUTY  = 128
) (
    input  logic             i_clk,
    input  logic             i_reset,
`ifdef PPS_SYNC_EN
    input  logic             i_pps_sync,
`endif
    pps_multi_blink_if.slave wr,
    output logic [NCHAN-1:0] o_led,
    output logic             o_pps
);

    localparam cnt_t LAST = cnt_t'(CLOCK_RATE_HZ - 1);

    cnt_t counter, counter_next;
    logic wrap;
    logic force_wrap;

`ifdef PPS_SYNC_EN
    // Two synchroniser stages plus one history bit for the rising-edge detect.
    logic [2:0] sync_q;
    logic       force_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q  <= '0;
            force_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], i_pps_sync};
            force_q <= sync_q[1] & ~sync_q[2];
        end
    end

    // A forced wrap right after a wrap would start a second frame of length one,
    // so an edge landing on the natural wrap yields a single strobe.
    assign force_wrap = force_q & ~o_pps;
`else
    assign force_wrap = 1'b0;
`endif

    always_comb begin
        wrap         = (counter == LAST) || force_wrap;
        counter_next = wrap ? '0 : counter + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            counter <= '0;
            o_pps   <= 1'b0;
        end else begin
            counter <= counter_next;
            o_pps   <= wrap;
        end
    end

    // Out-of-range channel indices match no channel and are dropped.
    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        logic wr_en;
        assign wr_en = wr.wr_stb && (int'(wr.wr_chan) == c);

        pps_chan #(
            .CLOCK_RATE_HZ (CLOCK_RATE_HZ),
            .DUTY_BITS     (DUTY_BITS),
            .DEFAULT_DUTY  (DEFAULT_DUTY)
        ) u_chan (
            .i_clk        (i_clk),
            .i_reset      (i_reset),
            .counter_next (counter_next),
            .wrap         (wrap),
            .wr_en        (wr_en),
            .wr_duty      (wr.wr_duty),
            .o_led        (o_led[c])
        );
    end

`ifdef FORMAL
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            a_cnt_range: assert (counter < CLOCK_RATE_HZ);
            if (o_pps) a_pps_zero: assert (counter == '0);
        end
    end
`endif

endmodule

// File: tb/tb_pps_multi_blink.sv
// Self-checking bench for pps_multi_blink (RATE=1000, 4 channels, 8-bit duty): directed
// frame scenarios with literal expectations, then randomized writes/resets against a frame model.
module tb_pps_multi_blink;

  localparam int RATE = 1000;
  localparam int NCH  = 4;
  localparam int DB   = 8;
  localparam int DEF  = 128;
  localparam int DMAX = (1 << DB) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] led;
  logic pps;
`ifdef PPS_SYNC_EN
  logic pps_sync;
`endif

  always #5 clk = ~clk;

  pps_multi_blink_if #(.NCHAN(NCH), .DUTY_BITS(DB)) wr_bus ();

  pps_multi_blink #(
    .CLOCK_RATE_HZ (RATE),
    .NCHAN         (NCH),
    .DUTY_BITS     (DB),
    .DEFAULT_DUTY  (DEF)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
`ifdef PPS_SYNC_EN
    .i_pps_sync (pps_sync),
`endif
    .wr         (wr_bus),
    .o_led      (led),
    .o_pps      (pps)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Frame model: each frame starts at a wrap, and during a frame an LED is lit for the
  // first (duty*RATE)/256 cycles of it, or for the whole frame at full-scale duty.
  bit             m_valid = 0;
  int             m_phase;
  int             m_frame_duty [NCH];
  int             m_pend [NCH];
  logic [NCH-1:0] exp_led;
  logic           exp_pps;
  int             abs_cyc = 0;
  int             force_at [$];
  logic           m_sync_prev;

  always @(posedge clk) begin
    bit wrap;
    int cur;
    cur = abs_cyc;
    abs_cyc++;
    if (rst) begin
      m_valid = 1;
      m_phase = 0;
      exp_led = '0;
      exp_pps = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_frame_duty[c] = 0;
        m_pend[c]       = DEF;
      end
      force_at.delete();
      m_sync_prev = 1'b0;
    end else if (m_valid) begin
      wrap = (m_phase == RATE - 1);
`ifdef PPS_SYNC_EN
      // An input edge first seen at cycle t starts a new frame at cycle t+3,
      // unless a frame started on the cycle just before.
      if (force_at.size() > 0 && force_at[0] == cur) begin
        void'(force_at.pop_front());
        if (!exp_pps) wrap = 1;
      end
      if (pps_sync && !m_sync_prev) force_at.push_back(cur + 3);
      m_sync_prev = pps_sync;
`endif
      if (wr_bus.wr_stb && int'(wr_bus.wr_chan) < NCH)
        m_pend[int'(wr_bus.wr_chan)] = int'(wr_bus.wr_duty);
      if (wrap) begin
        m_phase      = 0;
        m_frame_duty = m_pend;
      end else begin
        m_phase++;
      end
      exp_pps = wrap;
      for (int c = 0; c < NCH; c++)
        exp_led[c] = (m_frame_duty[c] == DMAX) || (m_phase < (m_frame_duty[c] * RATE) / 256);
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("led_vs_model", 32'(led), 32'(exp_led));
      check("pps_vs_model", 32'(pps), 32'(exp_pps));
    end
  end

  task automatic drive_wr(input int c, input int d);
    wr_bus.wr_stb  = 1'b1;
    wr_bus.wr_chan = 2'(c);
    wr_bus.wr_duty = 8'(d);
  endtask

  int hi [5][NCH];
  int dark_hi [NCH];
  int light_hi [NCH];
  int pps_log [$];
  int exp_hi [5][NCH];
  int exp_pps_cyc [7];
  int pps_win;

  initial begin
    rst = 1'b1;
    wr_bus.wr_stb  = 1'b0;
    wr_bus.wr_chan = '0;
    wr_bus.wr_duty = '0;
`ifdef PPS_SYNC_EN
    pps_sync = 1'b0;
`endif
    exp_hi = '{'{0, 0, 0, 0}, '{500, 500, 500, 500}, '{500, 500, 250, 500},
               '{0, 1000, 250, 125}, '{0, 1000, 250, 781}};
    exp_pps_cyc = '{1000, 2000, 3000, 4000, 5000, 6501, 7501};
    foreach (hi[f, c]) hi[f][c] = 0;
    for (int c = 0; c < NCH; c++) begin
      dark_hi[c]  = 0;
      light_hi[c] = 0;
    end

    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 32'd0);
    check("reset_pps", 32'(pps), 32'd0);
    check("reset_counter", dut.counter, 32'd0);
    rst = 1'b0;

    // Directed run; loop index k is the cycle number, counter == 0 at k == 0.
    for (int k = 0; k < 7600; k++) begin
      if (k < 5000)
        for (int c = 0; c < NCH; c++) hi[k / 1000][c] += int'(led[c]);
      if (k >= 5501 && k <= 6500)
        for (int c = 0; c < NCH; c++) dark_hi[c] += int'(led[c]);
      if (k >= 6501 && k <= 7500)
        for (int c = 0; c < NCH; c++) light_hi[c] += int'(led[c]);
      if (pps) pps_log.push_back(k);
      if (k == 5501) begin
        check("midreset_counter", dut.counter, 32'd0);
        check("midreset_led", 32'(led), 32'd0);
      end

      wr_bus.wr_stb = 1'b0;
      rst = 1'b0;
      case (k)
        1300: drive_wr(2, 64);
        2400: drive_wr(0, 0);
        2450: drive_wr(1, 255);
        2999: drive_wr(3, 32);
        3300: drive_wr(3, 16);
        3800: drive_wr(3, 200);
        5200: drive_wr(0, 20);
        5500: begin rst = 1'b1; drive_wr(2, 10); end
        default: ;
      endcase
      @(negedge clk);
    end
    wr_bus.wr_stb = 1'b0;

    foreach (hi[f, c]) check($sformatf("hi_f%0d_ch%0d", f, c), hi[f][c], exp_hi[f][c]);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("dark_after_reset_ch%0d", c), dark_hi[c], 32'd0);
      check($sformatf("default_after_reset_ch%0d", c), light_hi[c], 32'd500);
    end
    check("pps_count", pps_log.size(), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < pps_log.size()) check($sformatf("pps_cycle_%0d", i), pps_log[i], exp_pps_cyc[i]);

    // Randomized writes and occasional resets, checked cycle by cycle against the model.
    for (int k = 0; k < 20000; k++) begin
      wr_bus.wr_stb = 1'b0;
      rst = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: drive_wr($urandom_range(0, NCH - 1), 0);
          1: drive_wr($urandom_range(0, NCH - 1), DMAX);
          default: drive_wr($urandom_range(0, NCH - 1), $urandom_range(0, DMAX));
        endcase
      end
      @(negedge clk);
    end
    wr_bus.wr_stb = 1'b0;

`ifdef PPS_SYNC_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pps_log.delete();
    for (int k = 0; k < 2600; k++) begin
      if (pps) pps_log.push_back(k);
      pps_sync = (k >= 400 && k < 410) || (k >= 1400 && k < 1410) || (k >= 2401 && k < 2411);
      @(negedge clk);
    end
    pps_sync = 1'b0;
    check("sync_first_pps", (pps_log.size() > 0) ? pps_log[0] : -1, 32'd404);
    check("sync_second_pps", (pps_log.size() > 1) ? pps_log[1] : -1, 32'd1404);
    pps_win = 0;
    foreach (pps_log[i]) if (pps_log[i] >= 2350 && pps_log[i] < 2500) pps_win++;
    check("sync_on_wrap_single", pps_win, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
